// File: rtl/tag_fifo_pkg.sv
// ---------------------------------------------------------------------------
// tag_fifo_pkg
// Shared definitions for the rename-tag allocator of the Tomasulo back end.
//   TAG_WIDTH    : default width of a rename tag
//   tag_t        : rename tag type, shared with cdb_bus.cdb_tag and the
//                  dispatcher rd_tag fields
//   push_mode_e  : which of the two return sources write the FIFO this cycle
// ---------------------------------------------------------------------------
package tag_fifo_pkg;

  localparam int TAG_WIDTH = 6;

  typedef logic [TAG_WIDTH-1:0] tag_t;

  // Write-side decode: CDB always takes the first slot, the direct release
  // takes the slot behind it when both are accepted.
  typedef enum logic [1:0] {
    PUSH_NONE = 2'd0,
    PUSH_CDB  = 2'd1,
    PUSH_REL  = 2'd2,
    PUSH_BOTH = 2'd3
  } push_mode_e;

endpackage

// File: rtl/tag_fifo_inflight.sv
// ---------------------------------------------------------------------------
// tag_fifo_inflight
// One bit per rename tag, set while the tag is owned by an instruction
// (handed out by the FIFO and not yet returned). Reports whether a tag may
// legally come back.
//   i_clk, i_rst          : clock, synchronous active-high reset (clears map)
//   i_set_en/i_set_tag    : tag handed out this cycle
//   i_clr0_en/i_clr0_tag  : accepted CDB return
//   i_clr1_en/i_clr1_tag  : accepted direct release
//   i_chk0_tag/o_legal0   : legality of a CDB return of this tag
//   i_chk1_tag/o_legal1   : legality of a direct release of this tag
// ---------------------------------------------------------------------------
module tag_fifo_inflight
  import tag_fifo_pkg::*;
#(
  parameter int TAG_WIDTH     = tag_fifo_pkg::TAG_WIDTH,
  parameter int RESERVED_TAGS = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_set_en,
  input  logic [TAG_WIDTH-1:0] i_set_tag,
  input  logic                 i_clr0_en,
  input  logic [TAG_WIDTH-1:0] i_clr0_tag,
  input  logic                 i_clr1_en,
  input  logic [TAG_WIDTH-1:0] i_clr1_tag,
  input  logic [TAG_WIDTH-1:0] i_chk0_tag,
  output logic                 o_legal0,
  input  logic [TAG_WIDTH-1:0] i_chk1_tag,
  output logic                 o_legal1
);

  localparam int NUM_TAGS = 2**TAG_WIDTH;

  // Reserved low tags are masked out so they can never be returned, even if
  // something upstream misbehaves.
  localparam logic [NUM_TAGS-1:0] ISSUABLE_MASK = {NUM_TAGS{1'b1}} << RESERVED_TAGS;

  logic [NUM_TAGS-1:0] r_inflight;

  // Clears are applied before the set so a same-cycle hand-out always wins.
  // A tag being handed out is by construction not in flight, so its own
  // returns are illegal that cycle and never reach the clear ports.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_inflight <= '0;
    end else begin
      if (i_clr0_en) begin
        r_inflight[i_clr0_tag] <= 1'b0;
      end
      if (i_clr1_en) begin
        r_inflight[i_clr1_tag] <= 1'b0;
      end
      if (i_set_en) begin
        r_inflight[i_set_tag] <= 1'b1;
      end
    end
  end

  // A return is legal only for an issuable tag that is currently out.
  always_comb begin
    o_legal0 = r_inflight[i_chk0_tag] & ISSUABLE_MASK[i_chk0_tag];
    o_legal1 = r_inflight[i_chk1_tag] & ISSUABLE_MASK[i_chk1_tag];
  end

endmodule

// File: rtl/tag_fifo.sv
// ---------------------------------------------------------------------------
// tag_fifo
// Free rename-tag allocator: a circular FIFO of free tags with show-ahead
// read, two return sources (CDB broadcast, direct release) and a sticky
// error flag for illegal returns or pops while empty.
//   clk, rst                   : clock, synchronous active-high reset
//   alloc_req                  : dispatcher pops the head tag
//   alloc_tag / alloc_valid    : head tag, valid when the FIFO is not empty
//   tag_fifo_empty             : no free tags, dispatcher must stall
//   cdb_valid / cdb_tag        : tag returned by a CDB broadcast
//   release_en / release_tag   : tag returned directly (stores, branches)
//   free_count                 : number of free tags held
//   tag_err                    : sticky illegal-return / empty-pop flag
// ---------------------------------------------------------------------------
module tag_fifo
  import tag_fifo_pkg::*;
#(
  parameter int TAG_WIDTH     = tag_fifo_pkg::TAG_WIDTH,
  parameter int RESERVED_TAGS = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_req,
  output logic [TAG_WIDTH-1:0] alloc_tag,
  output logic                 alloc_valid,
  output logic                 tag_fifo_empty,
  input  logic                 cdb_valid,
  input  logic [TAG_WIDTH-1:0] cdb_tag,
  input  logic                 release_en,
  input  logic [TAG_WIDTH-1:0] release_tag,
  output logic [TAG_WIDTH:0]   free_count,
  output logic                 tag_err
);

  localparam int NUM_TAGS = 2**TAG_WIDTH;
  localparam int NUM_FREE = NUM_TAGS - RESERVED_TAGS;

  // Initial write pointer wraps to 0 when no tags are reserved (FIFO full).
  localparam logic [TAG_WIDTH-1:0] WR_PTR_INIT = TAG_WIDTH'(NUM_FREE);
  localparam logic [TAG_WIDTH:0]   FREE_INIT   = (TAG_WIDTH+1)'(NUM_FREE);

  logic [TAG_WIDTH-1:0] r_mem [NUM_TAGS];
  logic [TAG_WIDTH-1:0] r_rd_ptr;
  logic [TAG_WIDTH-1:0] r_wr_ptr;
  logic [TAG_WIDTH:0]   r_free_count;
  logic                 r_tag_err;

  logic                 w_alloc_valid;
  logic                 w_pop;
  logic                 w_cdb_legal;
  logic                 w_rel_legal;
  logic                 w_cdb_ok;
  logic                 w_rel_ok;
  logic                 w_same_tag;
  logic                 w_err_event;
  logic [TAG_WIDTH-1:0] w_wr_ptr_plus1;
  logic [TAG_WIDTH-1:0] w_ptr_inc;
  logic [TAG_WIDTH:0]   w_push_count;
  logic [TAG_WIDTH:0]   w_pop_count;
  push_mode_e           w_push_mode;

  // Ownership bitmap; a tag becomes owned when popped and is released by
  // whichever return source is accepted for it.
  tag_fifo_inflight #(
    .TAG_WIDTH     (TAG_WIDTH),
    .RESERVED_TAGS (RESERVED_TAGS)
  ) u_inflight (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_set_en   (w_pop),
    .i_set_tag  (alloc_tag),
    .i_clr0_en  (w_cdb_ok),
    .i_clr0_tag (cdb_tag),
    .i_clr1_en  (w_rel_ok),
    .i_clr1_tag (release_tag),
    .i_chk0_tag (cdb_tag),
    .o_legal0   (w_cdb_legal),
    .i_chk1_tag (release_tag),
    .o_legal1   (w_rel_legal)
  );

  // Show-ahead read side and return acceptance. Empty versus full cannot be
  // told from the pointers (they are equal in both cases), so the free count
  // alone decides validity. When both sources return the same tag only the
  // CDB copy is kept so the FIFO never holds a duplicate.
  always_comb begin
    alloc_tag      = r_mem[r_rd_ptr];
    w_alloc_valid  = (r_free_count != '0);
    alloc_valid    = w_alloc_valid;
    tag_fifo_empty = !w_alloc_valid;
    free_count     = r_free_count;
    tag_err        = r_tag_err;

    w_pop          = alloc_req && w_alloc_valid;
    w_cdb_ok       = cdb_valid && w_cdb_legal;
    w_same_tag     = w_cdb_ok && release_en && w_rel_legal && (cdb_tag == release_tag);
    w_rel_ok       = release_en && w_rel_legal && !w_same_tag;
    w_err_event    = (alloc_req && !w_alloc_valid) ||
                     (cdb_valid && !w_cdb_legal) ||
                     (release_en && !w_rel_legal) ||
                     w_same_tag;
    w_wr_ptr_plus1 = r_wr_ptr + TAG_WIDTH'(1);
    w_pop_count    = {{TAG_WIDTH{1'b0}}, w_pop};
  end

  // Write-side decode: how many slots are written and where each goes.
  always_comb begin
    w_push_mode  = PUSH_NONE;
    w_ptr_inc    = '0;
    w_push_count = '0;
    case ({w_cdb_ok, w_rel_ok})
      2'b10: begin
        w_push_mode  = PUSH_CDB;
        w_ptr_inc    = TAG_WIDTH'(1);
        w_push_count = (TAG_WIDTH+1)'(1);
      end
      2'b01: begin
        w_push_mode  = PUSH_REL;
        w_ptr_inc    = TAG_WIDTH'(1);
        w_push_count = (TAG_WIDTH+1)'(1);
      end
      2'b11: begin
        w_push_mode  = PUSH_BOTH;
        w_ptr_inc    = TAG_WIDTH'(2);
        w_push_count = (TAG_WIDTH+1)'(2);
      end
      default: begin
        w_push_mode  = PUSH_NONE;
      end
    endcase
  end

  // Tag storage. Reset refills the FIFO with every issuable tag in ascending
  // order; slots beyond that are unused until returns land in them.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_TAGS; i++) begin
        r_mem[i] <= (i < NUM_FREE) ? TAG_WIDTH'(RESERVED_TAGS + i) : '0;
      end
    end else begin
      case (w_push_mode)
        PUSH_CDB: begin
          r_mem[r_wr_ptr] <= cdb_tag;
        end
        PUSH_REL: begin
          r_mem[r_wr_ptr] <= release_tag;
        end
        PUSH_BOTH: begin
          r_mem[r_wr_ptr]       <= cdb_tag;
          r_mem[w_wr_ptr_plus1] <= release_tag;
        end
        default: begin
        end
      endcase
    end
  end

  // Pointers, occupancy and the sticky error. Pointers wrap naturally at
  // NUM_TAGS because they are exactly TAG_WIDTH bits wide.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= WR_PTR_INIT;
      r_free_count <= FREE_INIT;
      r_tag_err    <= 1'b0;
    end else begin
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + TAG_WIDTH'(1);
      end
      r_wr_ptr     <= r_wr_ptr + w_ptr_inc;
      r_free_count <= r_free_count - w_pop_count + w_push_count;
      if (w_err_event) begin
        r_tag_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tag_fifo.sv
// ---------------------------------------------------------------------------
// tb_tag_fifo
// Self-checking bench for tag_fifo (TAG_WIDTH=6, RESERVED_TAGS=0). A queue
// holds the free tags in the order the allocator must hand them out; returns
// push onto it and every pop is compared against its head.
// ---------------------------------------------------------------------------
module tb_tag_fifo;
  import tag_fifo_pkg::*;

  logic       clk;
  logic       rst;
  logic       alloc_req;
  tag_t       alloc_tag;
  logic       alloc_valid;
  logic       tag_fifo_empty;
  logic       cdb_valid;
  tag_t       cdb_tag;
  logic       release_en;
  tag_t       release_tag;
  logic [6:0] free_count;
  logic       tag_err;

  tag_t       sbq[$];
  bit [63:0]  mInflight;
  bit         mErr;
  int         nTests;
  int         nFail;

  tag_fifo #(
    .TAG_WIDTH     (6),
    .RESERVED_TAGS (0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .alloc_req      (alloc_req),
    .alloc_tag      (alloc_tag),
    .alloc_valid    (alloc_valid),
    .tag_fifo_empty (tag_fifo_empty),
    .cdb_valid      (cdb_valid),
    .cdb_tag        (cdb_tag),
    .release_en     (release_en),
    .release_tag    (release_tag),
    .free_count     (free_count),
    .tag_err        (tag_err)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous reset for one edge; the model forgets every outstanding tag.
  task automatic applyReset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    alloc_req = 1'b0;
    cdb_valid = 1'b0;
    release_en = 1'b0;
    sbq.delete();
    for (int i = 0; i < 64; i++) sbq.push_back(tag_t'(i));
    mInflight = '0;
    mErr      = 1'b0;
  endtask

  // Drive one cycle of stimulus and advance the reference model by the
  // behaviour the allocator must show at that edge. Called #1 after an edge.
  task automatic applyStimulus(input bit pop, input bit cv, input int ct,
                               input bit re, input int rt);
    bit   cLegal, rLegal, cAcc, rAcc, didPop;
    tag_t popped;
    alloc_req   = pop;
    cdb_valid   = cv;
    cdb_tag     = tag_t'(ct);
    release_en  = re;
    release_tag = tag_t'(rt);
    cLegal = mInflight[ct];
    rLegal = mInflight[rt];
    cAcc   = cv && cLegal;
    rAcc   = re && rLegal && !(cAcc && ct == rt);
    didPop = 1'b0;
    popped = '0;
    if (pop) begin
      if (sbq.size() != 0) begin
        popped = sbq.pop_front();
        didPop = 1'b1;
      end else begin
        mErr = 1'b1;
      end
    end
    if (cv && !cLegal) mErr = 1'b1;
    if (re && !rLegal) mErr = 1'b1;
    if (cAcc && re && rLegal && ct == rt) mErr = 1'b1;
    if (cAcc) begin
      sbq.push_back(tag_t'(ct));
      mInflight[ct] = 1'b0;
    end
    if (rAcc) begin
      sbq.push_back(tag_t'(rt));
      mInflight[rt] = 1'b0;
    end
    if (didPop) mInflight[popped] = 1'b1;
    @(posedge clk);
    #1;
    alloc_req  = 1'b0;
    cdb_valid  = 1'b0;
    release_en = 1'b0;
  endtask

  task automatic test_reset();
    applyReset();
    nTests++;
    if (free_count !== 7'd64) begin
      nFail++; $display("[TB] FAIL reset_free_count: got %0d want 64", free_count);
    end
    nTests++;
    if (alloc_valid !== 1'b1 || tag_fifo_empty !== 1'b0) begin
      nFail++; $display("[TB] FAIL reset_valid: got valid=%b empty=%b want 1/0", alloc_valid, tag_fifo_empty);
    end
    nTests++;
    if (tag_err !== 1'b0) begin
      nFail++; $display("[TB] FAIL reset_err: got %b want 0", tag_err);
    end
    nTests++;
    if (alloc_tag !== 6'd0) begin
      nFail++; $display("[TB] FAIL reset_head: got %0d want 0", alloc_tag);
    end
  endtask

  // 64 back-to-back pops must hand out 0..63 in order, then stall.
  task automatic test_drain();
    applyReset();
    for (int k = 0; k < 64; k++) begin
      nTests++;
      if (alloc_valid !== 1'b1 || alloc_tag !== sbq[0]) begin
        nFail++; $display("[TB] FAIL drain_pop%0d: got tag=%0d valid=%b want tag=%0d valid=1", k, alloc_tag, alloc_valid, sbq[0]);
      end
      applyStimulus(1, 0, 0, 0, 0);
    end
    nTests++;
    if (tag_fifo_empty !== 1'b1 || free_count !== 7'd0) begin
      nFail++; $display("[TB] FAIL drain_empty: got empty=%b free=%0d want 1/0", tag_fifo_empty, free_count);
    end
  endtask

  // From empty: pop while empty flags the error; a CDB return is poppable
  // the next cycle.
  task automatic test_refill_from_empty();
    applyStimulus(1, 0, 0, 0, 0);
    nTests++;
    if (tag_err !== mErr || free_count !== 7'd0) begin
      nFail++; $display("[TB] FAIL empty_pop: got err=%b free=%0d want err=%b free=0", tag_err, free_count, mErr);
    end
    applyStimulus(0, 1, 17, 0, 0);
    nTests++;
    if (alloc_valid !== 1'b1 || alloc_tag !== sbq[0] || free_count !== 7'(sbq.size())) begin
      nFail++; $display("[TB] FAIL refill17: got valid=%b tag=%0d free=%0d want 1/%0d/%0d", alloc_valid, alloc_tag, free_count, sbq[0], sbq.size());
    end
    nTests++;
    if (alloc_tag !== 6'd17) begin
      nFail++; $display("[TB] FAIL refill17_head: got %0d want 17", alloc_tag);
    end
  endtask

  // Dual return queues both behind the untouched tags, CDB first.
  task automatic test_back_to_back();
    applyReset();
    for (int k = 0; k < 4; k++) applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 2, 1, 3);
    nTests++;
    if (free_count !== 7'd62 || tag_err !== 1'b0) begin
      nFail++; $display("[TB] FAIL dual_return: got free=%0d err=%b want 62/0", free_count, tag_err);
    end
    for (int k = 1; k <= 62; k++) begin
      nTests++;
      if (alloc_tag !== sbq[0]) begin
        nFail++; $display("[TB] FAIL b2b_pop%0d: got %0d want %0d", k, alloc_tag, sbq[0]);
      end
      if (k == 61 || k == 62) begin
        nTests++;
        if (alloc_tag !== tag_t'(k - 59)) begin
          nFail++; $display("[TB] FAIL b2b_order%0d: got %0d want %0d", k, alloc_tag, k - 59);
        end
      end
      applyStimulus(1, 0, 0, 0, 0);
    end
    nTests++;
    if (tag_fifo_empty !== 1'b1) begin
      nFail++; $display("[TB] FAIL b2b_empty: got %b want 1", tag_fifo_empty);
    end
  endtask

  // Returning the same tag twice counts it once and flags the second.
  task automatic test_double_free();
    applyReset();
    for (int k = 0; k < 6; k++) applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 5, 0, 0);
    nTests++;
    if (tag_err !== 1'b0 || free_count !== 7'd59) begin
      nFail++; $display("[TB] FAIL first_free5: got err=%b free=%0d want 0/59", tag_err, free_count);
    end
    applyStimulus(0, 0, 0, 1, 5);
    nTests++;
    if (tag_err !== 1'b1 || free_count !== 7'd59) begin
      nFail++; $display("[TB] FAIL double_free5: got err=%b free=%0d want 1/59", tag_err, free_count);
    end
  endtask

  // Same tag on both ports: one entry written, error raised; drain checks
  // the tag appears only once.
  task automatic test_same_tag();
    applyReset();
    for (int k = 0; k < 10; k++) applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 9, 1, 9);
    nTests++;
    if (free_count !== 7'd55 || tag_err !== 1'b1) begin
      nFail++; $display("[TB] FAIL same_tag9: got free=%0d err=%b want 55/1", free_count, tag_err);
    end
    for (int k = 0; k < 55; k++) begin
      nTests++;
      if (alloc_tag !== sbq[0]) begin
        nFail++; $display("[TB] FAIL same_drain%0d: got %0d want %0d", k, alloc_tag, sbq[0]);
      end
      applyStimulus(1, 0, 0, 0, 0);
    end
    nTests++;
    if (free_count !== 7'd0 || alloc_valid !== 1'b0) begin
      nFail++; $display("[TB] FAIL same_end: got free=%0d valid=%b want 0/0", free_count, alloc_valid);
    end
  endtask

  // Pop and push together; the tag popped this cycle cannot come back yet.
  task automatic test_pop_return_same_cycle();
    applyReset();
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 1, 1);
    nTests++;
    if (free_count !== 7'd63 || tag_err !== 1'b1) begin
      nFail++; $display("[TB] FAIL pop_push: got free=%0d err=%b want 63/1", free_count, tag_err);
    end
    nTests++;
    if (alloc_tag !== 6'd2) begin
      nFail++; $display("[TB] FAIL pop_push_head: got %0d want 2", alloc_tag);
    end
  endtask

  // Mid-run reset overrides inputs and forgets every outstanding tag.
  task automatic test_mid_reset();
    applyReset();
    for (int k = 0; k < 20; k++) applyStimulus(1, 0, 0, 0, 0);
    alloc_req = 1'b1;
    cdb_valid = 1'b1;
    cdb_tag   = 6'd3;
    applyReset();
    nTests++;
    if (free_count !== 7'd64 || alloc_tag !== 6'd0 || tag_err !== 1'b0) begin
      nFail++; $display("[TB] FAIL mid_reset: got free=%0d tag=%0d err=%b want 64/0/0", free_count, alloc_tag, tag_err);
    end
    applyStimulus(0, 1, 7, 0, 0);
    nTests++;
    if (tag_err !== 1'b1 || free_count !== 7'd64) begin
      nFail++; $display("[TB] FAIL stale_return: got err=%b free=%0d want 1/64", tag_err, free_count);
    end
  endtask

  // Scenario sequence.
  initial begin
    nTests      = 0;
    nFail       = 0;
    rst         = 1'b1;
    alloc_req   = 1'b0;
    cdb_valid   = 1'b0;
    cdb_tag     = '0;
    release_en  = 1'b0;
    release_tag = '0;
    mInflight   = '0;
    mErr        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_drain();
    test_refill_from_empty();
    test_back_to_back();
    test_double_free();
    test_same_tag();
    test_pop_return_same_cycle();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
